// File: rtl/huffman_canon_decoder.sv
// Canonical-Huffman symbol decoder: serial MSB-first bits matched against per-length
// MINCODE/MAXCODE/VALPTR tables, symbol fetched from a loadable RAM. Optional counters: HUFF_DECODER_STATS_EN.
module huffman_canon_decoder #(
  parameter int MAX_LEN    = 16,
  parameter int NUM_TABLES = 4,
  parameter int NUM_SYMS   = 256,
  parameter int SYM_W      = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          start_in,
  input  logic [$clog2(NUM_TABLES)-1:0] table_sel_in,
  input  logic                          bit_in,
  input  logic                          bit_valid_in,
  output logic                          bit_ready_out,
  output logic [SYM_W-1:0]              sym_out,
  output logic [4:0]                    codelen_out,
  output logic                          sym_valid_out,
  input  logic                          sym_ready_in,
  output logic                          error_out,
  output logic                          busy_out,
  input  logic                          cfg_len_we_in,
  input  logic [$clog2(NUM_TABLES)-1:0] cfg_table_in,
  input  logic [4:0]                    cfg_len_in,
  input  logic                          cfg_len_en_in,
  input  logic [MAX_LEN-1:0]            cfg_mincode_in,
  input  logic [MAX_LEN-1:0]            cfg_maxcode_in,
  input  logic [$clog2(NUM_SYMS)-1:0]   cfg_valptr_in,
  input  logic                          cfg_sym_we_in,
  input  logic [$clog2(NUM_SYMS)-1:0]   cfg_sym_addr_in,
  input  logic [SYM_W-1:0]              cfg_sym_data_in
`ifdef HUFF_DECODER_STATS_EN
  ,
  output logic [31:0]                   stat_syms_out,
  output logic [15:0]                   stat_errs_out,
  output logic [31:0]                   stat_bits_out
`endif
);

  localparam int TW = $clog2(NUM_TABLES);
  localparam int IW = $clog2(NUM_SYMS);
  localparam int AW = TW + IW;
  localparam int LW = $clog2(MAX_LEN);
  localparam int SW = (MAX_LEN > IW) ? MAX_LEN : IW;
  localparam logic [4:0] MAX_LEN_5 = 5'(MAX_LEN);

  // state   | meaning
  // S_IDLE  | waiting for start_in; config writes accepted
  // S_SHIFT | accepting bits and matching against the selected table
  // S_FETCH | symbol RAM read in flight
  // S_OUT   | symbol presented until sym_ready_in
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FETCH = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [TW-1:0]      tbl_q;
  logic [MAX_LEN-2:0] code_q;
  logic [4:0]         len_q;

  logic               len_en_q  [NUM_TABLES][MAX_LEN];
  logic [MAX_LEN-1:0] mincode_q [NUM_TABLES][MAX_LEN];
  logic [MAX_LEN-1:0] maxcode_q [NUM_TABLES][MAX_LEN];
  logic [IW-1:0]      valptr_q  [NUM_TABLES][MAX_LEN];

  logic [SYM_W-1:0]   sym_mem [NUM_TABLES*NUM_SYMS];
  logic [SYM_W-1:0]   ram_q;

  logic               bit_hs;
  logic [MAX_LEN-1:0] code_n;
  logic [4:0]         len_n;
  logic [LW-1:0]      len_idx;
  logic               hit;
  logic               last_bit;
  logic [IW-1:0]      sym_idx;
  logic [AW-1:0]      ram_addr;
  logic               ram_we;
  logic               ram_en;
  logic               cfg_len_ok;
  logic [LW-1:0]      cfg_idx;

  // Entries for length L live at index L-1, i.e. the length before this bit.
  assign bit_hs   = (state_q == S_SHIFT) && bit_valid_in;
  assign code_n   = {code_q, bit_in};
  assign len_n    = len_q + 5'd1;
  assign len_idx  = len_q[LW-1:0];
  assign hit      = len_en_q[tbl_q][len_idx] && (code_n <= maxcode_q[tbl_q][len_idx]);
  assign last_bit = (len_n == MAX_LEN_5);
  assign sym_idx  = IW'(SW'(valptr_q[tbl_q][len_idx]) + SW'(code_n)
                        - SW'(mincode_q[tbl_q][len_idx]));

  assign cfg_len_ok = (state_q == S_IDLE) && cfg_len_we_in
                      && (cfg_len_in != 5'd0) && (cfg_len_in <= MAX_LEN_5);
  assign cfg_idx    = LW'(cfg_len_in - 5'd1);

  // Single-port RAM: writes only happen in IDLE, reads only in SHIFT.
  assign ram_we   = (state_q == S_IDLE) && cfg_sym_we_in;
  assign ram_en   = ram_we || (bit_hs && hit);
  assign ram_addr = (state_q == S_SHIFT) ? {tbl_q, sym_idx} : {cfg_table_in, cfg_sym_addr_in};

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_SHIFT;
      S_SHIFT: begin
        if (bit_hs) begin
          if (hit)           state_d = S_FETCH;
          else if (last_bit) state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_OUT;
      S_OUT:   if (sym_ready_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bit_ready_out = (state_q == S_SHIFT);
    sym_valid_out = (state_q == S_OUT);
    busy_out      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tbl_q       <= '0;
      code_q      <= '0;
      len_q       <= '0;
      sym_out     <= '0;
      codelen_out <= '0;
      error_out   <= 1'b0;
    end else begin
      error_out <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            tbl_q  <= table_sel_in;
            code_q <= '0;
            len_q  <= '0;
          end
        end
        S_SHIFT: begin
          if (bit_hs) begin
            code_q    <= code_n[MAX_LEN-2:0];
            len_q     <= len_n;
            error_out <= !hit && last_bit;
          end
        end
        S_FETCH: begin
          sym_out     <= ram_q;
          codelen_out <= len_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int t = 0; t < NUM_TABLES; t++)
        for (int l = 0; l < MAX_LEN; l++)
          len_en_q[t][l] <= 1'b0;
    end else if (cfg_len_ok) begin
      len_en_q[cfg_table_in][cfg_idx] <= cfg_len_en_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (cfg_len_ok && !rst_in) begin
      mincode_q[cfg_table_in][cfg_idx] <= cfg_mincode_in;
      maxcode_q[cfg_table_in][cfg_idx] <= cfg_maxcode_in;
      valptr_q[cfg_table_in][cfg_idx]  <= cfg_valptr_in;
    end
  end

  // Read-first: a write cycle returns the old contents on ram_q.
  always_ff @(posedge clk_in) begin
    if (ram_en) begin
      ram_q <= sym_mem[ram_addr];
      if (ram_we) sym_mem[ram_addr] <= cfg_sym_data_in;
    end
  end

`ifdef HUFF_DECODER_STATS_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_syms_out <= '0;
      stat_errs_out <= '0;
      stat_bits_out <= '0;
    end else begin
      if (sym_valid_out && sym_ready_in && (stat_syms_out != '1))
        stat_syms_out <= stat_syms_out + 32'd1;
      if (error_out && (stat_errs_out != '1))
        stat_errs_out <= stat_errs_out + 16'd1;
      if (bit_hs && (stat_bits_out != '1))
        stat_bits_out <= stat_bits_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_canon_decoder.sv
// Bench for huffman_canon_decoder: JPEG tables plus a small custom table, checked
// against a prefix-search model built from the canonical code list.
module tb_huffman_canon_decoder;
  localparam int MAX_LEN = 16, NUM_TABLES = 4, NUM_SYMS = 256, SYM_W = 8;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic         rst_in, start_in, bit_in, bit_valid_in, bit_ready_out;
  logic [1:0]   table_sel_in, cfg_table_in;
  logic [7:0]   sym_out;
  logic [4:0]   codelen_out, cfg_len_in;
  logic         sym_valid_out, sym_ready_in, error_out, busy_out;
  logic         cfg_len_we_in, cfg_len_en_in, cfg_sym_we_in;
  logic [15:0]  cfg_mincode_in, cfg_maxcode_in;
  logic [7:0]   cfg_valptr_in, cfg_sym_addr_in, cfg_sym_data_in;

  huffman_canon_decoder #(.MAX_LEN(MAX_LEN), .NUM_TABLES(NUM_TABLES),
                          .NUM_SYMS(NUM_SYMS), .SYM_W(SYM_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .table_sel_in(table_sel_in),
    .bit_in(bit_in), .bit_valid_in(bit_valid_in), .bit_ready_out(bit_ready_out),
    .sym_out(sym_out), .codelen_out(codelen_out), .sym_valid_out(sym_valid_out),
    .sym_ready_in(sym_ready_in), .error_out(error_out), .busy_out(busy_out),
    .cfg_len_we_in(cfg_len_we_in), .cfg_table_in(cfg_table_in), .cfg_len_in(cfg_len_in),
    .cfg_len_en_in(cfg_len_en_in), .cfg_mincode_in(cfg_mincode_in),
    .cfg_maxcode_in(cfg_maxcode_in), .cfg_valptr_in(cfg_valptr_in),
    .cfg_sym_we_in(cfg_sym_we_in), .cfg_sym_addr_in(cfg_sym_addr_in),
    .cfg_sym_data_in(cfg_sym_data_in)
  );

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int         tbits   [NUM_TABLES][16];
  logic [7:0] tvals   [NUM_TABLES][256];
  int         ref_n   [NUM_TABLES];
  int         ref_code[NUM_TABLES][256];
  int         ref_len [NUM_TABLES][256];
  logic [7:0] ref_val [NUM_TABLES][256];

  logic [7:0] ac_vals [162] = '{
    8'h01,8'h02,8'h03,8'h00,8'h04,8'h11,8'h05,8'h12,8'h21,8'h31,8'h41,8'h06,8'h13,8'h51,8'h61,8'h07,
    8'h22,8'h71,8'h14,8'h32,8'h81,8'h91,8'ha1,8'h08,8'h23,8'h42,8'hb1,8'hc1,8'h15,8'h52,8'hd1,8'hf0,
    8'h24,8'h33,8'h62,8'h72,8'h82,8'h09,8'h0a,8'h16,8'h17,8'h18,8'h19,8'h1a,8'h25,8'h26,8'h27,8'h28,
    8'h29,8'h2a,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,8'h3a,8'h43,8'h44,8'h45,8'h46,8'h47,8'h48,8'h49,
    8'h4a,8'h53,8'h54,8'h55,8'h56,8'h57,8'h58,8'h59,8'h5a,8'h63,8'h64,8'h65,8'h66,8'h67,8'h68,8'h69,
    8'h6a,8'h73,8'h74,8'h75,8'h76,8'h77,8'h78,8'h79,8'h7a,8'h83,8'h84,8'h85,8'h86,8'h87,8'h88,8'h89,
    8'h8a,8'h92,8'h93,8'h94,8'h95,8'h96,8'h97,8'h98,8'h99,8'h9a,8'ha2,8'ha3,8'ha4,8'ha5,8'ha6,8'ha7,
    8'ha8,8'ha9,8'haa,8'hb2,8'hb3,8'hb4,8'hb5,8'hb6,8'hb7,8'hb8,8'hb9,8'hba,8'hc2,8'hc3,8'hc4,8'hc5,
    8'hc6,8'hc7,8'hc8,8'hc9,8'hca,8'hd2,8'hd3,8'hd4,8'hd5,8'hd6,8'hd7,8'hd8,8'hd9,8'hda,8'he1,8'he2,
    8'he3,8'he4,8'he5,8'he6,8'he7,8'he8,8'he9,8'hea,8'hf1,8'hf2,8'hf3,8'hf4,8'hf5,8'hf6,8'hf7,8'hf8,
    8'hf9,8'hfa};

  // Canonical code assignment: consecutive codes per length, shift left between lengths.
  task automatic build_ref(input int t);
    int code, k;
    code = 0; k = 0;
    for (int l = 1; l <= 16; l++) begin
      for (int j = 0; j < tbits[t][l-1]; j++) begin
        ref_code[t][k] = code; ref_len[t][k] = l; ref_val[t][k] = tvals[t][k];
        k++; code++;
      end
      code = code << 1;
    end
    ref_n[t] = k;
  endtask

  task automatic model_decode(input int t, input logic [15:0] bits,
                              output logic [7:0] s, output int l, output bit e);
    s = 8'h00; l = 16; e = 1'b1;
    for (int ln = 1; ln <= 16; ln++) begin
      int prefix;
      prefix = int'(bits >> (16 - ln));
      for (int k = 0; k < ref_n[t]; k++)
        if (e && ref_len[t][k] == ln && ref_code[t][k] == prefix) begin
          s = ref_val[t][k]; l = ln; e = 1'b0;
        end
    end
  endtask

  task automatic load_table(input int t);
    int first, last;
    build_ref(t);
    @(negedge clk_in);
    for (int k = 0; k < ref_n[t]; k++) begin
      cfg_sym_we_in = 1'b1; cfg_table_in = 2'(t);
      cfg_sym_addr_in = 8'(k); cfg_sym_data_in = ref_val[t][k];
      @(negedge clk_in);
    end
    cfg_sym_we_in = 1'b0;
    for (int l = 1; l <= 16; l++) begin
      first = -1; last = -1;
      for (int k = 0; k < ref_n[t]; k++)
        if (ref_len[t][k] == l) begin
          if (first < 0) first = k;
          last = k;
        end
      cfg_len_we_in  = 1'b1; cfg_table_in = 2'(t); cfg_len_in = 5'(l);
      cfg_len_en_in  = (first >= 0);
      cfg_mincode_in = (first >= 0) ? 16'(ref_code[t][first]) : 16'h0;
      cfg_maxcode_in = (first >= 0) ? 16'(ref_code[t][last])  : 16'h0;
      cfg_valptr_in  = (first >= 0) ? 8'(first) : 8'h0;
      @(negedge clk_in);
    end
    cfg_len_we_in = 1'b0;
  endtask

  // Called at a negedge with the DUT idle. poke issues config writes while in SHIFT.
  task automatic run_decode(input string tag, input int t, input logic [15:0] bits,
                            input bit gapped, input int hold, input bit poke,
                            output logic [7:0] ds, output logic [4:0] dl);
    logic [7:0] es; int el; bit ee;
    int i, n, hs_n; bit done, got_sym, got_err, bad;
    model_decode(t, bits, es, el, ee);
    ds = 8'h00; dl = 5'h0;
    start_in = 1'b1; table_sel_in = 2'(t);
    bit_valid_in = 1'b1; bit_in = ~bits[15];
    @(negedge clk_in);
    start_in = 1'b0; bit_valid_in = 1'b0;
    i = 0; n = 0; hs_n = -10; done = 0; got_sym = 0; got_err = 0;
    while (!done && n < 400) begin
      if (sym_valid_out) begin got_sym = 1; done = 1; end
      else if (error_out) begin got_err = 1; done = 1; end
      else begin
        bit_valid_in = bit_ready_out && (i < 16) && (!gapped || (n % 3 == 0));
        bit_in = (i < 16) ? bits[4'(15 - i)] : 1'b0;
        if (poke && n == 0) begin
          cfg_sym_we_in = 1'b1; cfg_table_in = 2'(t); cfg_sym_addr_in = 8'h03; cfg_sym_data_in = 8'hAA;
          cfg_len_we_in = 1'b1; cfg_len_in = 5'd2; cfg_len_en_in = 1'b0;
          cfg_mincode_in = 16'h0; cfg_maxcode_in = 16'h0; cfg_valptr_in = 8'h0;
        end
        if (bit_valid_in) begin i++; hs_n = n; end
        @(negedge clk_in);
        bit_valid_in = 1'b0; cfg_sym_we_in = 1'b0; cfg_len_we_in = 1'b0;
        n++;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(got_err), 32'(ee));
    check({tag, "_bits"}, 32'(i), 32'(el));
    check({tag, "_lat"}, 32'(n - hs_n), ee ? 32'd1 : 32'd2);
    if (got_sym) begin
      ds = sym_out; dl = codelen_out;
      check({tag, "_sym"}, 32'(ds), 32'(es));
      check({tag, "_len"}, 32'(dl), 32'(el));
      bad = 0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk_in);
        if (sym_out !== ds || codelen_out !== dl || sym_valid_out !== 1'b1 || bit_ready_out !== 1'b0)
          bad = 1;
      end
      if (hold > 0) check({tag, "_hold"}, 32'(bad), 32'd0);
      sym_ready_in = 1'b1; start_in = 1'b1;
      @(negedge clk_in);
      sym_ready_in = 1'b0; start_in = 1'b0;
      check({tag, "_release"}, {30'd0, sym_valid_out, busy_out}, 32'd0);
    end else if (got_err) begin
      @(negedge clk_in);
      check({tag, "_pulse"}, {30'd0, error_out, busy_out}, 32'd0);
    end
  endtask

  task automatic direct(input string tag, input int t, input logic [15:0] bits, input bit gapped,
                        input int hold, input bit poke, input logic [7:0] xs, input logic [4:0] xl);
    logic [7:0] ds; logic [4:0] dl;
    run_decode(tag, t, bits, gapped, hold, poke, ds, dl);
    check({tag, "_const_sym"}, 32'(ds), 32'(xs));
    check({tag, "_const_len"}, 32'(dl), 32'(xl));
  endtask

  task automatic load_all();
    for (int t = 0; t < NUM_TABLES; t++) load_table(t);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ds; logic [4:0] dl;
    int t, k, ln, fill;
    logic [15:0] bits;

    rst_in = 1'b1; start_in = 0; table_sel_in = 0; bit_in = 0; bit_valid_in = 0; sym_ready_in = 0;
    cfg_len_we_in = 0; cfg_table_in = 0; cfg_len_in = 0; cfg_len_en_in = 0;
    cfg_mincode_in = 0; cfg_maxcode_in = 0; cfg_valptr_in = 0;
    cfg_sym_we_in = 0; cfg_sym_addr_in = 0; cfg_sym_data_in = 0;

    tbits[0] = '{0,1,5,1,1,1,1,1,1,0,0,0,0,0,0,0};
    tbits[1] = '{0,2,1,3,3,2,4,3,5,5,4,4,0,0,1,125};
    tbits[2] = '{0,3,1,1,1,1,1,1,1,1,1,0,0,0,0,0};
    tbits[3] = '{1,2,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    for (int i = 0; i < 256; i++) begin
      tvals[0][i] = 8'(i); tvals[2][i] = 8'(i);
      tvals[1][i] = (i < 162) ? ac_vals[i] : 8'h00;
      tvals[3][i] = 8'h00;
    end
    tvals[3][0] = 8'h5A; tvals[3][1] = 8'h3C; tvals[3][2] = 8'hC3;
    for (int i = 0; i < NUM_TABLES; i++) ref_n[i] = 0;

    repeat (3) @(negedge clk_in);
    check("rst_ready", 32'(bit_ready_out), 32'd0);
    check("rst_valid", 32'(sym_valid_out), 32'd0);
    check("rst_sym",   32'(sym_out), 32'd0);
    check("rst_len",   32'(codelen_out), 32'd0);
    check("rst_err",   32'(error_out), 32'd0);
    check("rst_busy",  32'(busy_out), 32'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    run_decode("empty_ones", 1, 16'hFFFF, 0, 0, 0, ds, dl);

    load_all();
    // Out-of-range lengths must not alias onto length 1 or length 16.
    cfg_table_in = 2'd1; cfg_len_we_in = 1'b1; cfg_len_en_in = 1'b1;
    cfg_mincode_in = 16'h0; cfg_maxcode_in = 16'hFFFF; cfg_valptr_in = 8'h0;
    cfg_len_in = 5'd17; @(negedge clk_in);
    cfg_len_en_in = 1'b0; cfg_len_in = 5'd0; @(negedge clk_in);
    cfg_len_we_in = 1'b0;

    direct("ac_00",     1, 16'h0000, 0, 5, 0, 8'h01, 5'd2);
    direct("ac_eob",    1, 16'hA000, 0, 0, 0, 8'h00, 5'd4);
    direct("ac_zrl",    1, 16'hFF20, 0, 1, 0, 8'hF0, 5'd11);
    direct("ac_zrl_gap",1, 16'hFF20, 1, 0, 0, 8'hF0, 5'd11);
    direct("ac_len16",  1, 16'hFFFE, 0, 0, 0, 8'hFA, 5'd16);
    direct("ldc_00",    0, 16'h0000, 0, 0, 0, 8'h00, 5'd2);
    direct("cdc_00",    2, 16'h0000, 0, 0, 0, 8'h00, 5'd2);
    direct("ldc_010",   0, 16'h4000, 1, 2, 0, 8'h01, 5'd3);
    direct("t3_len1",   3, 16'h0000, 0, 0, 0, 8'h5A, 5'd1);
    direct("t3_ones",   3, 16'hC000, 0, 0, 0, 8'hC3, 5'd2);
    run_decode("ac_ones16", 1, 16'hFFFF, 0, 0, 0, ds, dl);

    direct("poke_eob",  1, 16'hA000, 0, 0, 1, 8'h00, 5'd4);
    direct("poke_00",   1, 16'h0000, 0, 0, 0, 8'h01, 5'd2);

    start_in = 1'b1; table_sel_in = 2'd1; @(negedge clk_in); start_in = 1'b0;
    for (int j = 0; j < 3; j++) begin bit_valid_in = 1'b1; bit_in = 1'b1; @(negedge clk_in); end
    bit_valid_in = 1'b0;
    check("mid_busy", 32'(busy_out), 32'd1);
    rst_in = 1'b1; @(negedge clk_in);
    check("rst_mid_ready", 32'(bit_ready_out), 32'd0);
    check("rst_mid_busy",  32'(busy_out), 32'd0);
    rst_in = 1'b0;
    for (int i = 0; i < NUM_TABLES; i++) ref_n[i] = 0;
    @(negedge clk_in);
    run_decode("post_rst", 0, 16'h0000, 0, 0, 0, ds, dl);
    load_all();

    for (int it = 0; it < 150; it++) begin
      t = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, ref_n[t] - 1);
        ln = ref_len[t][k];
        fill = (ln < 16) ? int'($urandom_range(0, (1 << (16 - ln)) - 1)) : 0;
        bits = 16'((ref_code[t][k] << (16 - ln)) | fill);
      end else begin
        bits = 16'($urandom);
      end
      run_decode($sformatf("rnd%0d", it), t, bits, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), 0, ds, dl);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
